// File: rtl/lcd_driver_multiwin.sv
// lcd_driver_multiwin: parametrised LCD timing generator with an early pixel
// request and an outline-box overlay compositor.
// The counters produce HS/VS/DE, a request strobe that leads DE by H_AHEAD
// clocks, and a registered composite pixel. Box coordinates, enables and mode
// are captured at frame start, so a frame never mixes old and new settings.
// Optional feature: define LCD_TEST_PATTERN_EN to make mode 3 output eight
// vertical colour bars; without it mode 3 behaves as mode 1.
module lcd_driver_multiwin #(
    parameter int H_SYNC = 41,
    parameter int H_BACK = 2,
    parameter int H_DISP = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC = 10,
    parameter int V_BACK = 2,
    parameter int V_DISP = 272,
    parameter int V_FRONT = 2,
    parameter int H_AHEAD = 5,
    parameter int DATA_W = 24,
    parameter int NUM_BOX = 2,
    parameter int BOX_THICK = 2,
    parameter logic [DATA_W-1:0] BOX_COLOR = 24'hFF0000,
    parameter logic [DATA_W-1:0] BLANK_COLOR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [NUM_BOX-1:0]      box_en,
    input  logic [48*NUM_BOX-1:0]   box_coord,
    input  logic [DATA_W-1:0]       lcd_gray,
    input  logic [DATA_W-1:0]       lcd_data,
    output logic                    lcd_request,
    output logic [11:0]             lcd_xpos,
    output logic [11:0]             lcd_ypos,
    output logic                    frame_start,
    output logic                    lcd_hs,
    output logic                    lcd_vs,
    output logic                    lcd_en,
    output logic [DATA_W-1:0]       lcd_rgb
);

    // Counter limits and window edges, all sized to the 12-bit counters.
    localparam int H_TOTAL_I = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL_I = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL_I - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL_I - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] H_DE_START = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_DE_END   = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] H_RQ_START = 12'(H_SYNC + H_BACK - H_AHEAD);
    localparam logic [11:0] H_RQ_END   = 12'(H_SYNC + H_BACK + H_DISP - H_AHEAD);
    localparam logic [11:0] V_DE_START = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_DE_END   = 12'(V_SYNC + V_BACK + V_DISP);
    localparam logic [11:0] H_HALF     = 12'(H_DISP / 2);
    localparam logic [12:0] THICK      = 13'(BOX_THICK);

    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic        hs_raw;
    logic        vs_raw;
    logic        v_active;
    logic        de_raw;
    logic [11:0] px;
    logic [11:0] py;
    logic [12:0] px13;
    logic [12:0] py13;

    logic [1:0]             sh_mode;
    logic [NUM_BOX-1:0]     sh_en;
    logic [48*NUM_BOX-1:0]  sh_coord;

    logic [NUM_BOX-1:0]     box_hit;
    logic [DATA_W-1:0]      src_pixel;
    logic [DATA_W-1:0]      composite;

    // Horizontal and vertical position counters; vcnt steps at the end of each line.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= 12'd0;
            vcnt <= 12'd0;
        end else if (hcnt == H_LAST) begin
            hcnt <= 12'd0;
            if (vcnt == V_LAST) begin
                vcnt <= 12'd0;
            end else begin
                vcnt <= vcnt + 12'd1;
            end
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    // Raw sync and enable windows, decoded straight from the counters.
    assign hs_raw   = (hcnt >= H_SYNC_END);
    assign vs_raw   = (vcnt >= V_SYNC_END);
    assign v_active = (vcnt >= V_DE_START) && (vcnt < V_DE_END);
    assign de_raw   = (hcnt >= H_DE_START) && (hcnt < H_DE_END) && v_active;

    // The request window is the DE window pulled H_AHEAD clocks earlier, so a
    // source with H_AHEAD clocks of latency lines its pixel up with DE.
    assign lcd_request = (hcnt >= H_RQ_START) && (hcnt < H_RQ_END) && v_active;
    assign lcd_xpos    = lcd_request ? (hcnt - H_RQ_START) : 12'd0;
    assign lcd_ypos    = lcd_request ? (vcnt - V_DE_START) : 12'd0;

    // Held low during reset so the pulse lands in the first cycle after release.
    assign frame_start = !rst && (hcnt == 12'd0) && (vcnt == 12'd0);

    // Active-area coordinates of the pixel being composited this cycle.
    assign px   = hcnt - H_DE_START;
    assign py   = vcnt - V_DE_START;
    assign px13 = {1'b0, px};
    assign py13 = {1'b0, py};

    // Shadow copies of mode and box settings, refreshed only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode  <= 2'd0;
            sh_en    <= '0;
            sh_coord <= '0;
        end else if (frame_start) begin
            sh_mode  <= mode;
            sh_en    <= box_en;
            sh_coord <= box_coord;
        end
    end

    // One outline test per box: inside the thickened outer rectangle but not
    // strictly inside the original one. Lower outer edges clamp at zero;
    // upper outer edges may run past the display and simply never match.
    for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
        logic [12:0] xl;
        logic [12:0] xr;
        logic [12:0] yt;
        logic [12:0] yb;
        logic [12:0] ox_lo;
        logic [12:0] ox_hi;
        logic [12:0] oy_lo;
        logic [12:0] oy_hi;
        logic        valid;
        logic        in_outer;
        logic        in_inner;

        assign xl = {1'b0, sh_coord[48*i+36 +: 12]};
        assign xr = {1'b0, sh_coord[48*i+24 +: 12]};
        assign yt = {1'b0, sh_coord[48*i+12 +: 12]};
        assign yb = {1'b0, sh_coord[48*i    +: 12]};

        assign ox_lo = (xl >= THICK) ? (xl - THICK) : 13'd0;
        assign ox_hi = xr + THICK;
        assign oy_lo = (yt >= THICK) ? (yt - THICK) : 13'd0;
        assign oy_hi = yb + THICK;

        assign valid    = (xl <= xr) && (yt <= yb);
        assign in_outer = (px13 >= ox_lo) && (px13 <= ox_hi) &&
                          (py13 >= oy_lo) && (py13 <= oy_hi);
        assign in_inner = (px13 > xl) && (px13 < xr) &&
                          (py13 > yt) && (py13 < yb);

        assign box_hit[i] = sh_en[i] && valid && in_outer && !in_inner;
    end

`ifdef LCD_TEST_PATTERN_EN
    // Colour-bar generator: bar index is (px*8)/H_DISP, each channel fully on or off.
    localparam int CH_W = DATA_W / 3;
    localparam logic [14:0] H_DISP_W = 15'(H_DISP);

    logic [14:0]       px_x8;
    logic [2:0]        bar_idx;
    logic [2:0]        bar_rgb;
    logic [DATA_W-1:0] bar_pixel;

    assign px_x8   = {px, 3'b000};
    assign bar_idx = 3'(px_x8 / H_DISP_W);

    // Bar order white, yellow, cyan, green, magenta, red, blue, black as {R,G,B} flags.
    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            3'd0: bar_rgb = 3'b111;
            3'd1: bar_rgb = 3'b110;
            3'd2: bar_rgb = 3'b011;
            3'd3: bar_rgb = 3'b010;
            3'd4: bar_rgb = 3'b101;
            3'd5: bar_rgb = 3'b100;
            3'd6: bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    assign bar_pixel = DATA_W'({{CH_W{bar_rgb[2]}}, {CH_W{bar_rgb[1]}}, {CH_W{bar_rgb[0]}}});
`endif

    // Source selection by the shadowed mode; split switches at half width.
    always_comb begin
        src_pixel = lcd_data;
        case (sh_mode)
            2'd0: src_pixel = lcd_gray;
            2'd1: src_pixel = lcd_data;
            2'd2: src_pixel = (px < H_HALF) ? lcd_gray : lcd_data;
            default: begin
`ifdef LCD_TEST_PATTERN_EN
                src_pixel = bar_pixel;
`else
                src_pixel = lcd_data;
`endif
            end
        endcase
    end

    // Any box outline wins over the selected source.
    assign composite = (|box_hit) ? BOX_COLOR : src_pixel;

    // Output register stage: syncs and DE delayed one clock, pixel blanked outside DE.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_hs  <= 1'b1;
            lcd_vs  <= 1'b1;
            lcd_en  <= 1'b0;
            lcd_rgb <= BLANK_COLOR;
        end else begin
            lcd_hs  <= hs_raw;
            lcd_vs  <= vs_raw;
            lcd_en  <= de_raw;
            lcd_rgb <= de_raw ? composite : BLANK_COLOR;
        end
    end

endmodule
